// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: round-robin arbiter between two endpoint packet requesters
// plus a byte sequencer that emits PID, payload and CRC16 to the PHY port.
//
// Handshake (PHY side): a byte moves on every rising edge where
// tx_valid && tx_ready. While tx_valid is high and tx_ready is low, tx_data
// and tx_valid hold. The next byte is presented in the cycle right after
// acceptance. data_rd[g] is the matching combinational pop strobe toward the
// granted requester. It fires on the edge where that requester's head byte
// is copied into tx_data.
module usb_tx_sequencer #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [7:0]         pid_in,
  input  logic [2*LEN_W-1:0] len_in,
  input  logic [15:0]        data_in,
  output logic [1:0]         data_rd,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [2:0]         state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC_LO = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [2:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [15:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;   // payload bytes not yet loaded into tx_data
  logic             last_q, last_d; // 1: requester 1 was served last

  // One byte of the USB CRC16, LSB first, reflected polynomial 0xA001.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  logic             accept;
  logic [7:0]       head;
  logic             load_byte;
  logic             win;
  logic [3:0]       win_pid;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W-1:0] win_len_clamped;

  assign accept    = tx_valid_q & tx_ready;
  assign head      = grant_q[1] ? data_in[15:8] : data_in[7:0];
  assign load_byte = accept && ((state_q == S_PID) || (state_q == S_DATA))
                     && (cnt_q != '0);

  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 was served last.
  assign win             = req[1] & (~req[0] | ~last_q);
  assign win_pid         = win ? pid_in[7:4] : pid_in[3:0];
  assign win_len         = win ? len_in[2*LEN_W-1:LEN_W] : len_in[LEN_W-1:0];
  assign win_len_clamped = (win_len > MAX_LEN_L) ? MAX_LEN_L : win_len;

  // Pop strobe to the granted requester, suppressed during reset.
  assign data_rd = (load_byte && !reset) ? grant_q : 2'b00;

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_d    = win ? 2'b10 : 2'b01;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = {~win_pid, win_pid};
          cnt_d      = win_len_clamped;
          crc_d      = 16'hFFFF;
          state_d    = S_PID;
        end
      end
      S_PID, S_DATA: begin
        if (accept) begin
          if (cnt_q != '0) begin
            tx_data_d = head;
            crc_d     = crc16_byte(crc_q, head);
            cnt_d     = cnt_q - LEN_W'(1);
            state_d   = S_DATA;
          end else begin
            tx_data_d = ~crc_q[7:0];
            state_d   = S_CRC_LO;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          tx_data_d = ~crc_q[15:8];
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          done_d     = 1'b1;
          grant_d    = 2'b00;
          busy_d     = 1'b0;
          last_d     = grant_q[1];
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        grant_d    = 2'b00;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        crc_d      = 16'h0000;
        cnt_d      = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      crc_q      <= 16'h0000;
      cnt_q      <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: byte streams are scored against an
// expected queue built from a bit-serial CRC16 model.
module tb_usb_tx_sequencer;
  localparam int LEN_W   = 7;
  localparam int MAX_LEN = 64;

  // Clock and DUT signals.
  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req;
  logic [7:0]         pid_in;
  logic [2*LEN_W-1:0] len_in;
  logic [15:0]        data_in;
  logic [1:0]         data_rd;
  logic [1:0]         grant;
  logic               busy;
  logic               done;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [2:0]         state_o;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .pid_in   (pid_in),
    .len_in   (len_in),
    .data_in  (data_in),
    .data_rd  (data_rd),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .state_o  (state_o)
  );

  // Scoreboard and monitor state.
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] d0_q[$];
  logic [7:0] d1_q[$];
  int         rd_cnt0, rd_cnt1, g0_cyc, g1_cyc, unstable, done_cnt;
  int         pid_cyc, last_acc, ready_mode, ready_idx;
  logic [1:0] pkt_grant;
  logic [1:0] pend_pop;
  logic       hold_prev;
  logic [7:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference for the USB CRC16 register update.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  task automatic refresh();
    data_in = {(d1_q.size() > 0) ? d1_q[0] : 8'h00, (d0_q.size() > 0) ? d0_q[0] : 8'h00};
  endtask

  // Queue the expected bytes of one packet using payload from a source queue.
  task automatic expect_pkt(input logic [3:0] pid, input int which, input int n, input int off);
    logic [15:0] crc;
    logic [7:0]  b;
    crc = 16'hFFFF;
    exp_q.push_back({~pid, pid});
    for (int i = 0; i < n; i++) begin
      b = (which == 1) ? d1_q[off + i] : d0_q[off + i];
      exp_q.push_back(b);
      crc = crc_model(crc, b);
    end
    exp_q.push_back(~crc[7:0]);
    exp_q.push_back(~crc[15:8]);
  endtask

  // Driver/monitor for one clock: drive tx_ready, sample on the falling edge,
  // then apply requester pops just after the rising edge.
  task automatic cycle();
    tx_ready = (ready_mode == 0) ? 1'b1 : ((ready_idx % 3) == 0);
    ready_idx++;
    @(negedge clk);
    cyc++;
    if (hold_prev && (tx_valid !== 1'b1 || tx_data !== prev_data)) unstable++;
    hold_prev = tx_valid && !tx_ready;
    prev_data = tx_data;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      last_acc = cyc;
    end
    if (tx_valid && pid_cyc < 0) begin
      pid_cyc   = cyc;
      pkt_grant = grant;
    end
    if (data_rd[0]) rd_cnt0++;
    if (data_rd[1]) rd_cnt1++;
    if (grant == 2'b01) g0_cyc++;
    if (grant == 2'b10) g1_cyc++;
    if (done) done_cnt++;
    pend_pop = data_rd;
    @(posedge clk);
    #1;
    if (pend_pop[0] && d0_q.size() > 0) d0_q.delete(0);
    if (pend_pop[1] && d1_q.size() > 0) d1_q.delete(0);
    refresh();
  endtask

  task automatic clear_mon();
    got_q.delete();
    rd_cnt0 = 0; rd_cnt1 = 0; g0_cyc = 0; g1_cyc = 0;
    unstable = 0; done_cnt = 0; pid_cyc = -1; last_acc = -1;
    hold_prev = 1'b0; ready_idx = 0;
  endtask

  // Run cycles until done is seen (bounded); optionally drop req afterwards.
  task automatic run_packet(input bit drop, input int budget);
    bit seen;
    seen = 1'b0;
    clear_mon();
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (done_cnt > 0) seen = 1'b1;
    end
    check("done_within_budget", seen, 1);
    if (drop) req = 2'b00;
  endtask

  task automatic score(input string tag, input int n);
    check({tag, "_byte_count"}, got_q.size(), n);
    for (int i = 0; i < got_q.size(); i++) begin
      if (exp_q.size() > 0) check({tag, "_byte"}, got_q[i], exp_q.pop_front());
      else check({tag, "_byte_extra"}, got_q[i], 32'hFFFF_FFFF);
    end
  endtask

  int c0, la, rd_snap;

  initial begin
    reset = 1'b1; req = 2'b00; pid_in = 8'h00; len_in = '0; data_in = 16'h0000;
    tx_ready = 1'b1; ready_mode = 0; hold_prev = 1'b0; pend_pop = 2'b00;
    clear_mon();
    cycle();
    cycle();
    check("rst_state", state_o, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", tx_data, 0);
    check("rst_data_rd", data_rd, 0);

    // Zero-length packet from requester 0: C3, 00, 00.
    reset = 1'b0;
    pid_in = 8'h03; len_in = '0;
    expect_pkt(4'h3, 0, 0, 0);
    c0 = cyc;
    req = 2'b01;
    run_packet(1, 20);
    score("len0", 3);
    // req is first sampled on the edge closing cycle c0+1, PID is seen in c0+2.
    check("len0_latency", pid_cyc, c0 + 2);
    check("len0_grant", pkt_grant, 2'b01);
    check("len0_grant_cycles", g0_cyc, 3);
    check("len0_data_rd", rd_cnt0 + rd_cnt1, 0);
    cycle();
    cycle();
    check("len0_done_once", done_cnt, 1);
    check("len0_idle_busy", busy, 0);

    // Requester 1, three payload bytes, tx_ready always high.
    pid_in = 8'hB0; len_in = {7'd3, 7'd0};
    d1_q = '{8'h11, 8'h22, 8'h33};
    refresh();
    expect_pkt(4'hB, 1, 3, 0);
    check("p1_pid_byte", exp_q[0], 8'h4B);
    req = 2'b10;
    run_packet(1, 40);
    score("p1", 6);
    check("p1_grant", pkt_grant, 2'b10);
    check("p1_rd1", rd_cnt1, 3);
    check("p1_rd0", rd_cnt0, 0);
    cycle();

    // Same packet with tx_ready pattern 1,0,0 repeating.
    d1_q = '{8'h11, 8'h22, 8'h33};
    refresh();
    expect_pkt(4'hB, 1, 3, 0);
    ready_mode = 1;
    req = 2'b10;
    run_packet(1, 80);
    ready_mode = 0;
    score("p1_stall", 6);
    check("p1_stall_stable", unstable, 0);
    check("p1_stall_rd1", rd_cnt1, 3);
    check("p1_stall_rd0", rd_cnt0, 0);
    cycle();

    // Both requesters held: grants 01, 10, 01 with lens 1, 2, 1.
    pid_in = 8'h5A; len_in = {7'd2, 7'd1};
    d0_q = '{8'hA1, 8'hA2};
    d1_q = '{8'hB1, 8'hB2};
    refresh();
    expect_pkt(4'hA, 0, 1, 0);
    expect_pkt(4'h5, 1, 2, 0);
    expect_pkt(4'hA, 0, 1, 1);
    req = 2'b11;
    run_packet(0, 40);
    check("rr1_grant", pkt_grant, 2'b01);
    check("rr1_rd0", rd_cnt0, 1);
    score("rr1", 4);
    la = last_acc;
    run_packet(0, 40);
    check("rr2_grant", pkt_grant, 2'b10);
    // CRC_HI accepted on the edge closing cycle la; next PID registered two
    // edges later, so it is first sampled in cycle la+3.
    check("rr2_gap", pid_cyc - la, 3);
    check("rr2_rd1", rd_cnt1, 2);
    score("rr2", 5);
    la = last_acc;
    run_packet(1, 40);
    check("rr3_grant", pkt_grant, 2'b01);
    check("rr3_gap", pid_cyc - la, 3);
    check("rr3_rd0", rd_cnt0, 1);
    score("rr3", 4);
    cycle();

    // Length 100 clamps to 64 payload bytes.
    pid_in = 8'h0C; len_in = {7'd0, 7'd100};
    d0_q.delete();
    for (int i = 0; i < 100; i++) d0_q.push_back(8'((i * 7 + 1) & 8'hFF));
    refresh();
    expect_pkt(4'hC, 0, MAX_LEN, 0);
    req = 2'b01;
    run_packet(1, 300);
    score("clamp", MAX_LEN + 3);
    check("clamp_rd0", rd_cnt0, MAX_LEN);
    check("clamp_rd1", rd_cnt1, 0);
    cycle();

    // Reset in the middle of a payload, then requester 0 has priority again.
    d0_q.delete();
    for (int i = 0; i < 10; i++) d0_q.push_back(8'(8'h40 + i));
    refresh();
    len_in = {7'd0, 7'd10};
    clear_mon();
    req = 2'b01;
    cycle();
    cycle();
    cycle();
    check("mid_busy_before", busy, 1);
    check("mid_valid_before", tx_valid, 1);
    rd_snap = rd_cnt0;
    reset = 1'b1;
    cycle();
    check("mid_rd_during_reset", rd_cnt0, rd_snap);
    check("mid_valid_after", tx_valid, 0);
    check("mid_grant_after", grant, 0);
    check("mid_busy_after", busy, 0);
    reset = 1'b0;
    d0_q = '{8'h5E};
    d1_q = '{8'h6F};
    refresh();
    pid_in = 8'h21; len_in = {7'd1, 7'd1};
    expect_pkt(4'h1, 0, 1, 0);
    req = 2'b11;
    run_packet(1, 40);
    check("post_rst_grant", pkt_grant, 2'b01);
    score("post_rst", 4);
    check("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
